// File: rtl/register_file_scoreboard_if.sv
// register_file_scoreboard_if: bundles the write-back, issue, flush and
// operand-read signals between the pipeline and the register file.
// master = pipeline side (decode / write-back), slave = register file.
interface register_file_scoreboard_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            wbEnable;
    logic [AW-1:0]   wbAddr;
    logic [XLEN-1:0] wbData;
    logic [XLEN-1:0] wbPc;
    logic            issueEnable;
    logic [AW-1:0]   issueRd;
    logic            flush;
    logic [AW-1:0]   rs1Addr;
    logic [AW-1:0]   rs2Addr;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic            rs1Busy;
    logic            rs2Busy;
    logic            issueStall;
    logic [XLEN-1:0] lastWbPc;
    logic [31:0]     retiredCount;

    modport master (
        output wbEnable, wbAddr, wbData, wbPc,
        output issueEnable, issueRd, flush,
        output rs1Addr, rs2Addr,
        input  rs1Data, rs2Data, rs1Busy, rs2Busy,
        input  issueStall, lastWbPc, retiredCount
    );

    modport slave (
        input  wbEnable, wbAddr, wbData, wbPc,
        input  issueEnable, issueRd, flush,
        input  rs1Addr, rs2Addr,
        output rs1Data, rs2Data, rs1Busy, rs2Busy,
        output issueStall, lastWbPc, retiredCount
    );
endinterface

// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard: architectural integer register file (x0 reads 0)
// with a per-register pending-write scoreboard for RAW hazard detection,
// last retired PC and a retired-instruction counter.
// Optional feature macro: RF_WRITE_BYPASS_EN -- write-first forwarding of the
// same-cycle write-back onto the read ports, and early Busy release when that
// write-back retires the last pending write of the source register.
module register_file_scoreboard #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    parameter int PEND_W  = 2
) (
    input logic                       clk,
    input logic                       rst,
    register_file_scoreboard_if.slave bus
);
    localparam int                AW       = $clog2(REG_NUM);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [XLEN-1:0]   r_regs [REG_NUM];
    logic [PEND_W-1:0] r_pend [REG_NUM];
    logic [XLEN-1:0]   r_lastWbPc;
    logic [31:0]       r_retired;

    logic w_issueStall;
    logic w_issueHit;
    logic w_wbHit;
    logic w_rs1Fwd;
    logic w_rs2Fwd;

    // Saturating pending-count update; an issue and write-back to the same
    // register cancel out, and a write-back never drives the count below 0
    // (write-backs of flushed instructions are legal).
    function automatic logic [PEND_W-1:0] f_pend_next(
        input logic [PEND_W-1:0] cur,
        input logic              inc,
        input logic              dec
    );
        logic [PEND_W-1:0] nxt;
        nxt = cur;
        if (inc && !dec) begin
            nxt = cur + PEND_W'(1);
        end else if (dec && !inc && (cur != '0)) begin
            nxt = cur - PEND_W'(1);
        end
        return nxt;
    endfunction

    // A saturated counter blocks the issue so it can never wrap.
    assign w_issueStall = bus.issueEnable && (bus.issueRd != '0) &&
                          (r_pend[bus.issueRd] == PEND_MAX);
    assign w_issueHit   = bus.issueEnable && (bus.issueRd != '0) && !w_issueStall;
    assign w_wbHit      = bus.wbEnable && (bus.wbAddr != '0);

`ifdef RF_WRITE_BYPASS_EN
    assign w_rs1Fwd = w_wbHit && (bus.wbAddr == bus.rs1Addr);
    assign w_rs2Fwd = w_wbHit && (bus.wbAddr == bus.rs2Addr);
`else
    assign w_rs1Fwd = 1'b0;
    assign w_rs2Fwd = 1'b0;
`endif

    // Register array: reset clears everything and suppresses the same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wbHit) begin
            r_regs[bus.wbAddr] <= bus.wbData;
        end
    end

    // Scoreboard: flush and reset drop all in-flight writes; entry 0 stays 0.
    always_ff @(posedge clk) begin
        for (int i = 0; i < REG_NUM; i++) begin
            if (!rst || bus.flush || (i == 0)) begin
                r_pend[i] <= '0;
            end else begin
                r_pend[i] <= f_pend_next(r_pend[i],
                                         w_issueHit && (bus.issueRd == AW'(i)),
                                         w_wbHit && (bus.wbAddr == AW'(i)));
            end
        end
    end

    // Retire tracking: every write-back (including to x0) retires one instruction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lastWbPc <= '0;
            r_retired  <= '0;
        end else if (bus.wbEnable) begin
            r_lastWbPc <= bus.wbPc;
            r_retired  <= r_retired + 32'd1;
        end
    end

    assign bus.rs1Data = (bus.rs1Addr == '0) ? '0 :
                         w_rs1Fwd ? bus.wbData : r_regs[bus.rs1Addr];
    assign bus.rs2Data = (bus.rs2Addr == '0) ? '0 :
                         w_rs2Fwd ? bus.wbData : r_regs[bus.rs2Addr];

    assign bus.rs1Busy = (bus.rs1Addr != '0) && (r_pend[bus.rs1Addr] != '0) &&
                         !(w_rs1Fwd && (r_pend[bus.rs1Addr] == PEND_W'(1)));
    assign bus.rs2Busy = (bus.rs2Addr != '0) && (r_pend[bus.rs2Addr] != '0) &&
                         !(w_rs2Fwd && (r_pend[bus.rs2Addr] == PEND_W'(1)));

    assign bus.issueStall   = w_issueStall;
    assign bus.lastWbPc     = r_lastWbPc;
    assign bus.retiredCount = r_retired;
endmodule

// File: tb/tb_register_file_scoreboard.sv
// tb_register_file_scoreboard: directed and randomized stimulus for the
// register file / scoreboard, checked against an array-based reference model.
module tb_register_file_scoreboard;
    logic clk = 1'b0;
    logic rst;

    register_file_scoreboard_if #(.XLEN(32), .AW(5)) bus();

    register_file_scoreboard #(.XLEN(32), .REG_NUM(32), .PEND_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef RF_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int PMAX = 3;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    int          m_pend [32];
    logic [31:0] m_last;
    logic [31:0] m_ret;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst             = 1'b1;
        bus.wbEnable    = 1'b0;
        bus.wbAddr      = 5'd0;
        bus.wbData      = 32'd0;
        bus.wbPc        = 32'd0;
        bus.issueEnable = 1'b0;
        bus.issueRd     = 5'd0;
        bus.flush       = 1'b0;
        bus.rs1Addr     = 5'd0;
        bus.rs2Addr     = 5'd0;
    endtask

    function automatic bit m_stall();
        return bus.issueEnable && (bus.issueRd != 5'd0) && (m_pend[bus.issueRd] == PMAX);
    endfunction

    function automatic logic [31:0] m_data(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (BYPASS && bus.wbEnable && (bus.wbAddr == a)) return bus.wbData;
        return m_regs[a];
    endfunction

    function automatic bit m_busy(input logic [4:0] a);
        if (a == 5'd0 || m_pend[a] == 0) return 1'b0;
        if (BYPASS && bus.wbEnable && (bus.wbAddr == a) && m_pend[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    // Compare all outputs against the model at the falling edge.
    task automatic eval();
        @(negedge clk);
        chk("rs1Data", bus.rs1Data, m_data(bus.rs1Addr));
        chk("rs2Data", bus.rs2Data, m_data(bus.rs2Addr));
        chk("rs1Busy", {31'd0, bus.rs1Busy}, {31'd0, m_busy(bus.rs1Addr)});
        chk("rs2Busy", {31'd0, bus.rs2Busy}, {31'd0, m_busy(bus.rs2Addr)});
        chk("issueStall", {31'd0, bus.issueStall}, {31'd0, m_stall()});
        chk("lastWbPc", bus.lastWbPc, m_last);
        chk("retiredCount", bus.retiredCount, m_ret);
    endtask

    // Advance the model by one clock edge, then the DUT.
    task automatic commit();
        bit iss;
        bit wb;
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_pend[i] = 0;
            end
            m_last = 32'd0;
            m_ret  = 32'd0;
        end else begin
            iss = bus.issueEnable && (bus.issueRd != 5'd0) && !m_stall();
            wb  = bus.wbEnable && (bus.wbAddr != 5'd0);
            if (wb) m_regs[bus.wbAddr] = bus.wbData;
            if (bus.wbEnable) begin
                m_last = bus.wbPc;
                m_ret  = m_ret + 32'd1;
            end
            if (bus.flush) begin
                for (int i = 0; i < 32; i++) m_pend[i] = 0;
            end else if (!(iss && wb && bus.issueRd == bus.wbAddr)) begin
                if (iss) m_pend[bus.issueRd]++;
                if (wb && m_pend[bus.wbAddr] > 0) m_pend[bus.wbAddr]--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        bus.wbEnable = 1'b1;
        bus.wbAddr   = a;
        bus.wbData   = d;
        bus.wbPc     = pc;
    endtask

    task automatic drive_issue(input logic [4:0] rd);
        bus.issueEnable = 1'b1;
        bus.issueRd     = rd;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 0;
        end
        m_last = 32'd0;
        m_ret  = 32'd0;

        // Reset: first edge leaves DUT state undefined beforehand, so no check.
        idle(); rst = 1'b0;
        commit();
        idle(); rst = 1'b0;
        eval(); commit();

        // Read every register after reset.
        for (int i = 0; i < 32; i++) begin
            idle();
            bus.rs1Addr = 5'(i);
            bus.rs2Addr = 5'(31 - i);
            eval();
            chk("rst_rs1Data", bus.rs1Data, 32'd0);
            chk("rst_rs1Busy", {31'd0, bus.rs1Busy}, 32'd0);
            chk("rst_retired", bus.retiredCount, 32'd0);
            commit();
        end

        // Write x5, read back; write x0 is dropped but retires.
        idle(); drive_wb(5'd5, 32'hDEADBEEF, 32'h100); eval(); commit();
        idle(); bus.rs1Addr = 5'd5; eval();
        chk("x5_data", bus.rs1Data, 32'hDEADBEEF);
        chk("x5_pc", bus.lastWbPc, 32'h100);
        chk("x5_ret", bus.retiredCount, 32'd1);
        commit();
        idle(); drive_wb(5'd0, 32'h1234, 32'h104); bus.rs2Addr = 5'd0; eval(); commit();
        idle(); bus.rs2Addr = 5'd0; eval();
        chk("x0_data", bus.rs2Data, 32'd0);
        chk("x0_ret", bus.retiredCount, 32'd2);
        chk("x0_pc", bus.lastWbPc, 32'h104);
        commit();

        // Saturate pend[7], then drain it and try to underflow.
        for (int k = 0; k < 3; k++) begin
            idle(); drive_issue(5'd7); eval();
            chk("x7_nostall", {31'd0, bus.issueStall}, 32'd0);
            commit();
        end
        idle(); drive_issue(5'd7); bus.rs1Addr = 5'd7; eval();
        chk("x7_stall", {31'd0, bus.issueStall}, 32'd1);
        chk("x7_busy", {31'd0, bus.rs1Busy}, 32'd1);
        commit();
        for (int k = 0; k < 3; k++) begin
            idle(); drive_wb(5'd7, 32'(k + 70), 32'h200 + 32'(k)); bus.rs1Addr = 5'd7; eval();
            chk("x7_drain_busy", {31'd0, bus.rs1Busy}, (k == 2 && BYPASS) ? 32'd0 : 32'd1);
            commit();
        end
        idle(); bus.rs1Addr = 5'd7; eval();
        chk("x7_clear", {31'd0, bus.rs1Busy}, 32'd0);
        commit();
        idle(); drive_wb(5'd7, 32'h77, 32'h210); eval(); commit();
        idle(); drive_issue(5'd7); bus.rs1Addr = 5'd7; eval();
        chk("x7_no_underflow_stall", {31'd0, bus.issueStall}, 32'd0);
        chk("x7_no_underflow_busy", {31'd0, bus.rs1Busy}, 32'd0);
        commit();

        // Same-cycle issue and write-back of x9 with pend=1.
        idle(); drive_wb(5'd9, 32'h11, 32'h300); eval(); commit();
        idle(); drive_issue(5'd9); eval(); commit();
        idle(); drive_issue(5'd9); drive_wb(5'd9, 32'h22, 32'h304); bus.rs1Addr = 5'd9; eval();
        chk("x9_same_cycle_data", bus.rs1Data, BYPASS ? 32'h22 : 32'h11);
        commit();
        idle(); bus.rs1Addr = 5'd9; eval();
        chk("x9_pend_kept", {31'd0, bus.rs1Busy}, 32'd1);
        chk("x9_data", bus.rs1Data, 32'h22);
        commit();

        // Flush overrides a same-cycle issue.
        idle(); drive_issue(5'd3); eval(); commit();
        idle(); drive_issue(5'd4); eval(); commit();
        idle(); drive_issue(5'd3); bus.flush = 1'b1; bus.rs1Addr = 5'd3; bus.rs2Addr = 5'd4; eval(); commit();
        idle(); bus.rs1Addr = 5'd3; bus.rs2Addr = 5'd4; eval();
        chk("flush_busy3", {31'd0, bus.rs1Busy}, 32'd0);
        chk("flush_busy4", {31'd0, bus.rs2Busy}, 32'd0);
        commit();

        // Reset mid-stream with pend[12]=2 and a concurrent write to x12.
        idle(); drive_issue(5'd12); eval(); commit();
        idle(); drive_issue(5'd12); eval(); commit();
        idle(); rst = 1'b0; drive_wb(5'd12, 32'hAA, 32'h400); bus.rs1Addr = 5'd12; eval(); commit();
        idle(); bus.rs1Addr = 5'd12; eval();
        chk("rst_x12_data", bus.rs1Data, 32'd0);
        chk("rst_x12_busy", {31'd0, bus.rs1Busy}, 32'd0);
        chk("rst_x12_ret", bus.retiredCount, 32'd0);
        commit();

        // Randomized traffic concentrated on a few registers to create hazards.
        for (int n = 0; n < 400; n++) begin
            idle();
            rst             = ($urandom_range(0, 59) != 0);
            bus.wbEnable    = 1'($urandom_range(0, 1));
            bus.wbAddr      = 5'($urandom_range(0, 7));
            bus.wbData      = $urandom;
            bus.wbPc        = $urandom;
            bus.issueEnable = 1'($urandom_range(0, 1));
            bus.issueRd     = 5'($urandom_range(0, 7));
            bus.flush       = ($urandom_range(0, 19) == 0);
            bus.rs1Addr     = 5'($urandom_range(0, 7));
            bus.rs2Addr     = 5'($urandom_range(0, 31));
            eval();
            commit();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
